// File: rtl/sram_access_unit_if.sv
// Request/response channel between the core datapath and the SRAM access unit.
// The master is the core. The slave is the access unit.
interface sram_access_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sram_access_unit.sv
// Single-outstanding load/store/push/pop front-end for a 256x8 SRAM.
// It owns the downward-growing stack pointer.
module sram_access_unit #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clk_valid,
  sram_access_unit_if.slave     bus,
  output logic [7:0]            sp,
  output logic                  sram_write_en,
  output logic [7:0]            sram_addr,
  output logic [7:0]            sram_data_out,
  input  logic [7:0]            sram_data_in
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_reg, state_next;
  logic [7:0] sp_reg, sp_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [1:0] op_reg, op_next;
  logic       err_reg, err_next;
  logic [7:0] rsp_data_reg, rsp_data_next;
  logic       rsp_err_reg, rsp_err_next;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      sp_reg       <= SP_RESET;
      addr_reg     <= 8'h00;
      wdata_reg    <= 8'h00;
      op_reg       <= OP_LOAD;
      err_reg      <= 1'b0;
      rsp_data_reg <= 8'h00;
      rsp_err_reg  <= 1'b0;
    end else if (clk_valid) begin
      state_reg    <= state_next;
      sp_reg       <= sp_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      op_reg       <= op_next;
      err_reg      <= err_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sp_next       = sp_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    op_next       = op_reg;
    err_next      = err_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    sram_write_en = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          op_next    = bus.req_op;
          wdata_next = bus.req_wdata;
          // PUSH writes at sp then decrements; POP pre-increments to reach the top entry.
          case (bus.req_op)
            OP_PUSH: addr_next = sp_reg;
            OP_POP:  addr_next = sp_reg + 8'd1;
            default: addr_next = bus.req_addr;
          endcase
          err_next   = ((bus.req_op == OP_PUSH) && (sp_reg < STACK_LIMIT)) ||
                       ((bus.req_op == OP_POP)  && (sp_reg == SP_RESET));
          state_next = EXEC;
        end
      end
      EXEC: begin
        sram_write_en = ((op_reg == OP_STORE) || (op_reg == OP_PUSH)) && !err_reg;
        rsp_err_next  = err_reg;
        if (((op_reg == OP_LOAD) || (op_reg == OP_POP)) && !err_reg) begin
          rsp_data_next = sram_data_in;
        end else begin
          rsp_data_next = 8'h00;
        end
        if (!err_reg && (op_reg == OP_PUSH)) begin
          sp_next = sp_reg - 8'd1;
        end else if (!err_reg && (op_reg == OP_POP)) begin
          sp_next = sp_reg + 8'd1;
        end
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign sp            = sp_reg;
  assign sram_addr     = addr_reg;
  assign sram_data_out = wdata_reg;

endmodule

// File: tb/tb_sram_access_unit.sv
// Bench for sram_access_unit: directed table, stack boundary, stall/backpressure,
// reset during EXEC, and random traffic checked against a stack/memory model.
module tb_sram_access_unit;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       clk_valid;
  logic [7:0] sp;
  logic       sram_write_en;
  logic [7:0] sram_addr;
  logic [7:0] sram_data_out;
  logic [7:0] sram_data_in;

  sram_access_unit_if bus ();

  sram_access_unit dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .clk_valid     (clk_valid),
    .bus           (bus),
    .sp            (sp),
    .sram_write_en (sram_write_en),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_data_in  (sram_data_in)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on effective edges only
  logic [7:0] mem [256];
  logic       mem_clear;
  int         we_count;

  assign sram_data_in = mem[sram_addr];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (clk_valid && sram_write_en) begin
      mem[sram_addr] <= sram_data_out;
    end
  end

  always @(posedge clk) begin
    if (mem_clear) we_count <= 0;
    else if (clk_valid && sram_write_en) we_count <= we_count + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a flat memory and a downward stack
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_sp = 8'hFF;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                          output logic [7:0] data, output logic err, output int writes);
    data = 8'h00; err = 1'b0; writes = 0;
    case (op)
      OP_LOAD:  data = ref_mem[addr];
      OP_STORE: begin ref_mem[addr] = wdata; writes = 1; end
      OP_PUSH: begin
        if (ref_sp < 8'h80) err = 1'b1;
        else begin ref_mem[ref_sp] = wdata; ref_sp = ref_sp - 8'd1; writes = 1; end
      end
      default: begin
        if (ref_sp == 8'hFF) err = 1'b1;
        else begin ref_sp = ref_sp + 8'd1; data = ref_mem[ref_sp]; end
      end
    endcase
  endtask

  task automatic do_reset();
    arst_n = 1'b0; mem_clear = 1'b1; clk_valid = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req_op = OP_LOAD; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_clear = 1'b0; arst_n = 1'b1;
    model_reset();
  endtask

  // One full transaction; lat counts effective edges from acceptance to rsp_valid
  task automatic do_txn(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output logic rerr, output int lat);
    int n;
    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_timeout", 32'(n < 50), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = bus.rsp_data;
    rerr  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_check(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata);
    logic [7:0] exp_data, got_data;
    logic exp_err, got_err;
    int exp_w, lat, w0;
    model_op(op, addr, wdata, exp_data, exp_err, exp_w);
    w0 = we_count;
    do_txn(op, addr, wdata, got_data, got_err, lat);
    check("rsp_data", 32'(got_data), 32'(exp_data));
    check("rsp_err",  32'(got_err),  32'(exp_err));
    check("sp",       32'(sp),       32'(ref_sp));
    check("latency",  32'(lat),      2);
    check("writes",   32'(we_count - w0), 32'(exp_w));
    $display("txn op=%0d addr=%02h wdata=%02h -> data=%02h err=%0d sp=%02h", op, addr, wdata, got_data, got_err, sp);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [7:0] exp_sp;
    int         exp_we;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] d;
    logic e;
    int lat, w0;

    vecs[0] = '{OP_STORE, 8'h10, 8'hA5, 8'h00, 1'b0, 8'hFF, 1};
    vecs[1] = '{OP_LOAD,  8'h10, 8'h00, 8'hA5, 1'b0, 8'hFF, 0};
    vecs[2] = '{OP_PUSH,  8'h00, 8'h11, 8'h00, 1'b0, 8'hFE, 1};
    vecs[3] = '{OP_PUSH,  8'h00, 8'h22, 8'h00, 1'b0, 8'hFD, 1};
    vecs[4] = '{OP_POP,   8'h00, 8'h00, 8'h22, 1'b0, 8'hFE, 0};
    vecs[5] = '{OP_POP,   8'h00, 8'h00, 8'h11, 1'b0, 8'hFF, 0};
    vecs[6] = '{OP_POP,   8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 0};

    do_reset();
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_we",        32'(sram_write_en), 0);
    check("rst_addr",      32'(sram_addr), 0);
    check("rst_dout",      32'(sram_data_out), 0);
    check("rst_sp",        32'(sp), 32'h FF);
    check("rst_rsp_data",  32'(bus.rsp_data), 0);
    check("rst_rsp_err",   32'(bus.rsp_err), 0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      w0 = we_count;
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, d, e, lat);
      check("tbl_data",    32'(d),  32'(vecs[i].exp_data));
      check("tbl_err",     32'(e),  32'(vecs[i].exp_err));
      check("tbl_sp",      32'(sp), 32'(vecs[i].exp_sp));
      check("tbl_writes",  32'(we_count - w0), 32'(vecs[i].exp_we));
      check("tbl_latency", 32'(lat), 2);
      $display("vec %0d op=%0d data=%02h err=%0d sp=%02h", i, vecs[i].op, d, e, sp);
    end
    check("mem_ff", 32'(mem[8'hFF]), 32'h11);
    check("mem_fe", 32'(mem[8'hFE]), 32'h22);

    // Stack limit boundary: fill down to STACK_LIMIT, one more push succeeds, next overflows
    do_reset();
    for (int i = 0; i < 127; i++) run_check(OP_PUSH, 8'h00, 8'(i));
    check("sp_at_limit", 32'(sp), 32'h80);
    run_check(OP_PUSH, 8'h00, 8'hA0);
    run_check(OP_PUSH, 8'h00, 8'hB0);
    check("mem_80", 32'(mem[8'h80]), 32'hA0);
    check("mem_7f_untouched", 32'(mem[8'h7F]), 32'h00);
    run_check(OP_POP, 8'h00, 8'h00);

    // Stall during EXEC, then backpressure in RESP
    do_reset();
    w0 = we_count;
    bus.req_op = OP_STORE; bus.req_addr = 8'h30; bus.req_wdata = 8'h77; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    clk_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_we",        32'(sram_write_en), 1);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 0);
      check("stall_mem",       32'(mem[8'h30]), 0);
      $display("stall cycle %0d we=%0d mem30=%02h", i, sram_write_en, mem[8'h30]);
    end
    clk_valid = 1'b1;
    @(posedge clk); #1;
    check("stall_commit",  32'(mem[8'h30]), 32'h77);
    check("stall_wcount",  32'(we_count - w0), 1);
    check("stall_rsp",     32'(bus.rsp_valid), 1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    bus.req_op = OP_LOAD; bus.req_addr = 8'h30; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_data",  32'(bus.rsp_data), 32'h77);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      $display("backpressure cycle %0d rsp_valid=%0d data=%02h", i, bus.rsp_valid, bus.rsp_data);
    end
    clk_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_gated_hold", 32'(bus.rsp_valid), 1);
    clk_valid = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp_release", 32'(bus.req_ready), 1);

    // Asynchronous reset during EXEC of a STORE
    do_reset();
    bus.req_op = OP_STORE; bus.req_addr = 8'h20; bus.req_wdata = 8'h5A; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("arst_pre_we", 32'(sram_write_en), 1);
    #2 arst_n = 1'b0;
    #1;
    check("arst_we_drop", 32'(sram_write_en), 0);
    @(posedge clk); #1;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("arst_idle",  32'(bus.req_ready), 1);
    check("arst_rspv",  32'(bus.rsp_valid), 0);
    check("arst_sp",    32'(sp), 32'hFF);
    check("arst_mem20", 32'(mem[8'h20]), 0);
    $display("reset mid-EXEC: we=%0d sp=%02h mem20=%02h", sram_write_en, sp, mem[8'h20]);

    // Random traffic, addresses biased toward the stack top so LOAD/STORE alias pushed data
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [7:0] a;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom_range(0, 255));
      run_check(op, a, 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_access_unit.md
Name: sram_access_unit

Overview:
Load/store and stack front-end that sits directly upstream of the 256x8 data SRAM, between the core datapath and the memory port. It accepts one request at a time over a valid/ready handshake: LOAD, STORE, PUSH or POP. It maintains the hardware stack pointer, drives the SRAM address, write-enable and write-data lines, and returns read data or an error over a valid/ready response channel. All state advances only on clock edges where clk_valid is high.

Parameters:
SP_RESET, 8'hFF, stack pointer value after reset; marks the empty-stack position.
STACK_LIMIT, 8'h80, lowest address a PUSH may write. Stack grows downward.

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
clk_valid  input  1  clock-enable qualifier; all registers hold when low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request; high iff state==IDLE
req_op  input  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
req_addr  input  8  address for LOAD/STORE; ignored for PUSH/POP
req_wdata  input  8  write data for STORE/PUSH
rsp_valid  output  1  response present; high iff state==RESP
rsp_ready  input  1  consumer accepts response
rsp_data  output  8  read data for LOAD/POP; 0 for STORE/PUSH/error
rsp_err  output  1  stack overflow/underflow on this request
sp  output  8  current stack pointer
sram_write_en  output  1  to SRAM write enable
sram_addr  output  8  to SRAM address
sram_data_out  output  8  to SRAM write data
sram_data_in  input  8  from SRAM; combinational read of memory[sram_addr]

Behaviour:
- Reset is asynchronous, active-low (arst_n), on clock clk. Reset values: state=IDLE, sp=SP_RESET, addr_q=0, wdata_q=0, op_q=0, err_q=0, rsp_data=0, rsp_err=0. Consequently req_ready=1, rsp_valid=0, sram_write_en=0, sram_addr=0, sram_data_out=0.
- An edge is "effective" iff clk_valid=1. With clk_valid=0, all registers hold; outputs are unchanged.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, on an effective edge with req_valid=1:
  - Capture op_q=req_op and wdata_q=req_wdata.
  - addr_q: req_addr for LOAD/STORE; sp for PUSH; sp+1 (8-bit) for POP.
  - err_q=1 if PUSH with sp<STACK_LIMIT (overflow), or POP with sp==SP_RESET (underflow); else 0.
  - Go to EXEC.
- EXEC:
  - sram_addr=addr_q and sram_data_out=wdata_q (combinational from registers).
  - sram_write_en=1 iff op_q is STORE/PUSH and err_q=0, so the SRAM writes on this effective edge.
  - On the effective edge:
    - LOAD/POP without error: rsp_data<=sram_data_in; otherwise rsp_data<=0.
    - rsp_err<=err_q.
    - PUSH without error: sp<=sp-1. POP without error: sp<=sp+1. Error: sp unchanged.
    - Go to RESP.
- RESP: rsp_valid=1; rsp_data and rsp_err are held stable. On an effective edge with rsp_ready=1, go to IDLE. With rsp_ready=0, stay in RESP indefinitely.
- Outside EXEC, sram_write_en=0. sram_addr and sram_data_out keep showing addr_q/wdata_q.
- Latency: accept edge → EXEC edge → rsp_valid visible. The minimum is 3 effective edges per transaction, including the handshake-out. There is no pipelining and no request is accepted while busy.
- Boundaries:
  - sp==STACK_LIMIT: PUSH succeeds and sp becomes STACK_LIMIT-1. The next PUSH overflows.
  - sp==SP_RESET: POP underflows with no SRAM access.
  - Stack region is not protected from LOAD/STORE.
- Reset asserted mid-EXEC: sram_write_en drops immediately (asynchronous). No SP update occurs; the unit returns to IDLE.

Test Plan:
- Reset, then STORE addr 8'h10 data 8'hA5, then LOAD 8'h10 → first rsp_err=0 and rsp_data=0; second rsp_data=8'hA5; sram_write_en high exactly one cycle.
- PUSH 8'h11, PUSH 8'h22 → sp FF→FE→FD, memory[FF]=11, memory[FE]=22. POP, POP → rsp_data 8'h22 then 8'h11; sp back to 8'hFF.
- POP right after reset → rsp_err=1, rsp_data=0, sp=8'hFF, no sram_write_en.
- STACK_LIMIT=8'hFE: PUSH, PUSH, PUSH → first two succeed, sp=8'hFD. Third gives rsp_err=1, sp stays 8'hFD, memory[FD] unchanged.
- Stall and backpressure: clk_valid=0 for 5 cycles during EXEC → no state change, no write committed. Then rsp_ready=0 for 4 effective cycles in RESP → rsp_valid and rsp_data held, req_ready=0.
- Assert arst_n=0 during EXEC of STORE 8'h20/8'h5A → sram_write_en falls immediately; after release state=IDLE, sp=SP_RESET, memory[20]=0.
